// File: rtl/soc_mul_pkg.sv
// soc_mul_pkg: shared widths, per-core FSM states and the multiply tag type
package soc_mul_pkg;
  localparam int DATA_W = 32;
  localparam int ID_W = 3;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef struct packed {
    logic valid;
    logic [ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/soc_mul_arbiter_if.sv
// soc_mul_arbiter_if: per-core request/response lanes plus the shared multiply-cell port
interface soc_mul_arbiter_if #(parameter int NUM_REQ = 4);
  import soc_mul_pkg::*;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] resp_valid;
  logic [NUM_REQ-1:0] resp_ready;
  logic [NUM_REQ*DATA_W-1:0] req_src1;
  logic [NUM_REQ*DATA_W-1:0] req_src2;
  logic [NUM_REQ*DATA_W-1:0] resp_data;
  logic [DATA_W-1:0] mul_src1;
  logic [DATA_W-1:0] mul_src2;
  logic [DATA_W-1:0] mul_result;
  modport master (
    output req_valid, req_src1, req_src2, resp_ready, mul_result,
    input  req_ready, resp_valid, resp_data, mul_src1, mul_src2
  );
  modport slave (
    input  req_valid, req_src1, req_src2, resp_ready, mul_result,
    output req_ready, resp_valid, resp_data, mul_src1, mul_src2
  );
endinterface

// File: rtl/soc_rr_arbiter.sv
// soc_rr_arbiter: combinational round-robin pick starting just after last_grant
module soc_rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);
  // Scan from farthest to nearest so the nearest requester after last_grant wins
  always_comb begin
    gnt_idx = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(last_grant) + k) % N]) gnt_idx = IW'((int'(last_grant) + k) % N);
    gnt_any = |req;
    gnt = gnt_any ? N'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/soc_mul_arbiter.sv
// soc_mul_arbiter: shares one pipelined multiply cell among NUM_REQ cores,
// round-robin issue, per-core result hold until consumed.
module soc_mul_arbiter
  import soc_mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LATENCY = 1
) (
  input logic clk,
  input logic reset_n,
  soc_mul_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state [NUM_REQ];
  state_t state_nxt [NUM_REQ];
  logic [DATA_W-1:0] hold [NUM_REQ];
  tag_t tag_pipe [MUL_LATENCY];
  tag_t tag_out;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] gnt_idx;
  logic [NUM_REQ-1:0] idle;
  logic [NUM_REQ-1:0] cap;
  logic [NUM_REQ-1:0] gnt;
  logic gnt_any;
  logic accept;
  assign tag_out = tag_pipe[MUL_LATENCY-1];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_core
    assign idle[g] = state[g] == IDLE;
    assign cap[g] = tag_out.valid && tag_out.id == ID_W'(g);
  end
  soc_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req(bus.req_valid & idle),
    .last_grant(last_grant),
    .gnt(gnt),
    .gnt_idx(gnt_idx),
    .gnt_any(gnt_any)
  );
  // Gate with reset_n so nothing is granted while reset is held
  assign accept = gnt_any & reset_n;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) for (int i = 0; i < NUM_REQ; i++) state[i] <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    for (int i = 0; i < NUM_REQ; i++)
      state_nxt[i] = state[i] == IDLE ? (gnt[i] ? BUSY : IDLE) :
                     state[i] == BUSY ? (cap[i] ? DONE : BUSY) :
                     (bus.resp_ready[i] ? IDLE : DONE);
  end
  always_comb begin
    bus.resp_valid = '0;
    bus.resp_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.resp_valid[i] = state[i] == DONE;
      bus.resp_data[i*DATA_W +: DATA_W] = hold[i];
    end
    bus.req_ready = accept ? gnt : '0;
    bus.mul_src1 = accept ? bus.req_src1[gnt_idx*DATA_W +: DATA_W] : '0;
    bus.mul_src2 = accept ? bus.req_src2[gnt_idx*DATA_W +: DATA_W] : '0;
  end
  // Tag pipeline tracks which core owns the product leaving the cell
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      last_grant <= IW'(NUM_REQ - 1);
      for (int k = 0; k < MUL_LATENCY; k++) tag_pipe[k] <= '0;
      for (int i = 0; i < NUM_REQ; i++) hold[i] <= '0;
    end else begin
      if (accept) last_grant <= gnt_idx;
      tag_pipe[0] <= {accept, ID_W'(gnt_idx)};
      for (int k = 1; k < MUL_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
      for (int i = 0; i < NUM_REQ; i++) if (cap[i]) hold[i] <= bus.mul_result;
    end
endmodule

// File: tb/tb_soc_mul_arbiter.sv
// tb_soc_mul_arbiter: directed vectors against hand-computed results, with a
// MUL_LATENCY-stage multiply cell model.
module tb_soc_mul_arbiter;
  localparam int N = 4;
  localparam int L = 1;
  logic clk = 0;
  logic reset_n = 1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  soc_mul_arbiter_if #(.NUM_REQ(N)) bus();
  soc_mul_arbiter #(.NUM_REQ(N), .MUL_LATENCY(L)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  logic [31:0] mpipe [L];
  always @(posedge clk) begin
    mpipe[0] <= bus.mul_src1 * bus.mul_src2;
    for (int k = 1; k < L; k++) mpipe[k] <= mpipe[k-1];
  end
  assign bus.mul_result = mpipe[L-1];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_src1[i*32 +: 32] = a;
    bus.req_src2[i*32 +: 32] = b;
  endtask
  task automatic grant_all(input string tag);
    bus.req_valid = '1;
    #1;
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_grant%0d", tag, k), 32'(bus.req_ready), 32'(1) << k);
      tick;
      bus.req_valid[k] = 1'b0;
      #1;
    end
    tick;
    check($sformatf("%s_valid", tag), 32'(bus.resp_valid), 32'hF);
  endtask
  task automatic consume_all(input string tag);
    bus.resp_ready = '1;
    tick;
    bus.resp_ready = '0;
    #1;
    check(tag, 32'(bus.resp_valid), 0);
  endtask
  initial begin
    logic [31:0] exp_w [4];
    logic [31:0] exp_bp [4];
    int grants, done, prev, n0, n3;
    exp_w = '{32'h1, 32'h0, 32'd15, 32'd1000000};
    exp_bp = '{32'd6, 32'd81, 32'd20, 32'd42};
    bus.req_valid = '0;
    bus.resp_ready = '0;
    bus.req_src1 = '0;
    bus.req_src2 = '0;
    #1 reset_n = 0;
    bus.req_valid = '1;
    set_op(0, 5, 5);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_resp_data", 32'(|bus.resp_data), 0);
    check("rst_mul_src1", bus.mul_src1, 0);
    check("rst_mul_src2", bus.mul_src2, 0);
    bus.req_valid = '0;
    tick;
    tick;
    reset_n = 1;
    tick;
    set_op(0, 7, 6);
    bus.req_valid = 4'b0001;
    #1;
    check("single_ready", 32'(bus.req_ready), 1);
    check("single_src1", bus.mul_src1, 7);
    check("single_src2", bus.mul_src2, 6);
    tick;
    bus.req_valid = '0;
    bus.resp_ready = 4'b0001;
    #1;
    check("single_c1_valid", 32'(bus.resp_valid), 0);
    check("single_c1_ready", 32'(bus.req_ready), 0);
    tick;
    check("single_c2_valid", 32'(bus.resp_valid), 1);
    check("single_c2_data", bus.resp_data[31:0], 42);
    tick;
    bus.resp_ready = '0;
    #1;
    check("single_idle", 32'(bus.resp_valid), 0);
    reset_n = 0;
    #1 reset_n = 1;
    for (int i = 0; i < N; i++) set_op(i, 32'h0000FFFF, 32'h00010001);
    grant_all("cont");
    for (int i = 0; i < N; i++) check($sformatf("cont_data%0d", i), bus.resp_data[i*32 +: 32], 32'hFFFFFFFF);
    consume_all("cont_consumed");
    set_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    set_op(1, 32'h80000000, 32'd2);
    set_op(2, 32'd3, 32'd5);
    set_op(3, 32'd1000, 32'd1000);
    grant_all("wrap");
    for (int i = 0; i < N; i++) check($sformatf("wrap_data%0d", i), bus.resp_data[i*32 +: 32], exp_w[i]);
    consume_all("wrap_consumed");
    set_op(1, 9, 9);
    bus.req_valid = 4'b0010;
    #1;
    check("bp_first_grant", 32'(bus.req_ready), 32'b0010);
    tick;
    bus.req_valid = '0;
    tick;
    tick;
    set_op(0, 2, 3);
    set_op(2, 4, 5);
    set_op(3, 6, 7);
    bus.req_valid = '1;
    bus.resp_ready = 4'b1101;
    grants = 0;
    done = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      check("bp_data1", bus.resp_data[63:32], 81);
      check("bp_valid1", 32'(bus.resp_valid[1]), 1);
      check("bp_nogrant1", 32'(bus.req_ready[1]), 0);
      grants += $countones(bus.req_ready);
      for (int i = 0; i < N; i++)
        if (i != 1 && bus.resp_valid[i]) begin
          done++;
          check($sformatf("bp_data%0d", i), bus.resp_data[i*32 +: 32], exp_bp[i]);
        end
      tick;
    end
    check("bp_grants", grants, 10);
    check("bp_done", done, 8);
    bus.req_valid = '0;
    tick;
    tick;
    tick;
    check("bp_drained", 32'(bus.resp_valid), 32'b0010);
    consume_all("bp_consumed");
    set_op(2, 11, 13);
    bus.req_valid = 4'b0100;
    #1;
    check("mid_grant2", 32'(bus.req_ready), 32'b0100);
    tick;
    bus.req_valid = '1;
    reset_n = 0;
    #1;
    check("mid_req_ready", 32'(bus.req_ready), 0);
    check("mid_resp_valid", 32'(bus.resp_valid), 0);
    check("mid_resp_data", 32'(|bus.resp_data), 0);
    check("mid_mul_src1", bus.mul_src1, 0);
    check("mid_mul_src2", bus.mul_src2, 0);
    tick;
    reset_n = 1;
    bus.req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("mid_no_resp%0d", c), 32'(bus.resp_valid), 0);
      tick;
    end
    bus.req_valid = '1;
    #1;
    check("mid_next_grant0", 32'(bus.req_ready), 1);
    bus.req_valid = 4'b1001;
    bus.resp_ready = '1;
    prev = 3;
    n0 = 0;
    n3 = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (|bus.req_ready) begin
        check("fair_alt", 32'(bus.req_ready), prev == 3 ? 32'b0001 : 32'b1000);
        prev = bus.req_ready[0] ? 0 : 3;
        if (prev == 0) n0++;
        else n3++;
      end
      tick;
    end
    check("fair_count0", n0, 34);
    check("fair_count3", n3, 33);
    bus.req_valid = '0;
    tick;
    tick;
    tick;
    check("fair_drained", 32'(bus.resp_valid), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/soc_mul_arbiter.md
SOC_MUL_ARBITER -- requirements
Module: soc_mul_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, meaning the number of requesting CPU cores; the legal range is 2..8.
REQ-002 Parameter MUL_LATENCY, default 1, meaning the number of cycles from operand presentation to mul_result valid in the shared multiply cell; the legal range is 1..4.
REQ-003 clk  in  1  single clock; every register in the block samples on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  NUM_REQ  per-core multiply request.
REQ-006 req_src1, req_src2  in  NUM_REQ*32  per-core operands; core i occupies bits [32i+31:32i].
REQ-007 req_ready  out  NUM_REQ  per-core grant; a request is accepted on a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-008 resp_valid  out  NUM_REQ  per-core result-available flag.
REQ-009 resp_data  out  NUM_REQ*32  per-core result, with the same packing as req_src1.
REQ-010 resp_ready  in  NUM_REQ  per-core result consume.
REQ-011 mul_src1, mul_src2  out  32  operands to the shared multiply cell.
REQ-012 mul_result  in  32  low 32 bits of the product from the cell, valid MUL_LATENCY cycles after the operands.

Function
REQ-013 Each core shall have a 3-state FSM: IDLE -> BUSY on accept; BUSY -> DONE on capture of its result; DONE -> IDLE on resp_valid & resp_ready.
REQ-014 req_ready[i] shall be 1 only when core i is in IDLE, req_valid[i]=1, and core i wins arbitration; at most one bit of req_ready shall be 1 per cycle.
REQ-015 Arbitration shall be round-robin.
  - The search starts at index (last_grant+1) mod NUM_REQ.
  - last_grant updates only on an accept.
  - Combinational, no bubble: one accept per cycle is possible.
REQ-016 mul_src1 and mul_src2 shall combinationally carry the granted core's operands; with no grant they shall hold 0.
REQ-017 On accept, the block shall push {valid=1, id} into a MUL_LATENCY-deep tag shift register; all other cycles shall push valid=0.
REQ-018 When the tag-pipeline output has valid=1, mul_result shall be registered into the hold register of core id, that core shall enter DONE, and resp_valid[id] shall be 1 the following cycle.
  - Total latency from accept to resp_valid is MUL_LATENCY+1 cycles.
REQ-019 resp_data[i] and resp_valid[i] shall hold stable while in DONE until consumed; back-pressure shall not stall other cores.
REQ-020 A core in BUSY or DONE shall not be granted; re-issue is possible at the earliest on the cycle after the consume.
REQ-021 resp_ready with resp_valid=0 shall be ignored, as shall req_valid deasserted before a grant.
REQ-022 Results shall be the unsigned low word, (src1*src2) mod 2^32; the block performs no arithmetic.
REQ-023 Up to min(NUM_REQ, MUL_LATENCY+1) operations may be in flight, with at most one per core.

Reset
REQ-024 Asserting reset_n=0 shall immediately clear, at any time including mid-operation:
  - all FSMs to IDLE;
  - the tag pipeline valids to 0;
  - last_grant to NUM_REQ-1, so core 0 has first priority;
  - the hold registers to 0.
REQ-025 During reset: req_ready=0, resp_valid=0, resp_data=0, mul_src1=mul_src2=0.
REQ-026 Results in flight at reset shall be discarded, with no response after release.

Structure
REQ-027 Package soc_mul_pkg shall hold the data width constant (32), the FSM state enumeration {IDLE, BUSY, DONE}, and the tag struct {valid, id}.
REQ-028 Round-robin selection shall be the sub-module soc_rr_arbiter, with inputs request vector and last_grant and outputs a one-hot grant and the grant index.
REQ-029 The multiply cell shall be instantiated outside this block; the bench shall model it as a MUL_LATENCY-stage register of src1*src2.

Verification
REQ-030 Single core: core0 requests 7*6 -> accepted in cycle 0, resp_valid[0]=1 with data 42 in cycle 2 (MUL_LATENCY=1); resp_ready -> IDLE.
REQ-031 Contention: all four cores valid in the same cycle after reset -> grants in order 0,1,2,3 on consecutive cycles; results 0x0000FFFF*0x00010001=0xFFFFFFFF reach the correct cores.
REQ-032 Wrap and overflow: 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; 0x80000000*2 -> 0x00000000.
REQ-033 Back-pressure: core1 holds resp_ready=0 for 10 cycles -> resp_data[1] stays stable, core1 gets no grant, cores 0/2/3 continue issuing and completing.
REQ-034 Reset mid-flight: reset_n=0 one cycle after accepting core2 -> all outputs 0 immediately; after release, no resp_valid[2]; the next grant goes to core0.
REQ-035 Fairness: cores 0 and 3 requesting continuously -> grants alternate 0,3,0,3 with no starvation over 100 cycles.
